// File: rtl/ifmap_skew_feeder.sv
// IFMap buffer read responder: owns the IFMap SRAM and feeds the MAC array west edge
// with per-row diagonal skew (row r lags row 0 by r cycles).
module ifmap_skew_feeder #(
  parameter int unsigned MAC_ROW        = 16,
  parameter int unsigned IFMAP_BITWIDTH = 16,
  parameter int unsigned IFMAP_ADDR_BIT = 9
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en_in,
  input  logic [IFMAP_ADDR_BIT-1:0]           wr_addr_in,
  input  logic [MAC_ROW*IFMAP_BITWIDTH-1:0]   wr_data_in,
  input  logic                                ifmap_start_in,
  input  logic [IFMAP_ADDR_BIT-1:0]           ifmap_addr_in,
  input  logic                                ifmap_read_en_in,
  output logic [MAC_ROW*IFMAP_BITWIDTH-1:0]   ifmap_data_out,
  output logic [MAC_ROW-1:0]                  ifmap_valid_out,
  output logic [MAC_ROW-1:0]                  ifmap_start_out,
  output logic                                ifmap_busy_out
);

  localparam int unsigned Depth = 2 ** IFMAP_ADDR_BIT;
  localparam int unsigned WordW = MAC_ROW * IFMAP_BITWIDTH;

  logic [WordW-1:0] mem [Depth];

  logic [WordW-1:0] rd_data_q, rd_data_d;
  logic             req_valid_q, req_valid_d;
  logic             req_start_q, req_start_d;

  logic [IFMAP_BITWIDTH-1:0] lane_data [MAC_ROW];
  logic                      lane_vld  [MAC_ROW];
  logic                      lane_stt  [MAC_ROW];
  logic                      lane_any  [MAC_ROW];

  // Nonblocking write alongside the registered read gives read-first on collision.
  always_ff @(posedge clk) begin
    if (wr_en_in) begin
      mem[wr_addr_in] <= wr_data_in;
    end
  end

  always_comb begin
    req_valid_d = ifmap_read_en_in;
    req_start_d = ifmap_start_in & ifmap_read_en_in;
    rd_data_d   = rd_data_q;
    if (ifmap_read_en_in) begin
      rd_data_d = mem[ifmap_addr_in];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q   <= '0;
      req_valid_q <= 1'b0;
      req_start_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      req_valid_q <= req_valid_d;
      req_start_q <= req_start_d;
    end
  end

  for (genvar r = 0; r < MAC_ROW; r++) begin : g_lane
    if (r == 0) begin : g_direct
      assign lane_data[r] = rd_data_q[IFMAP_BITWIDTH-1:0];
      assign lane_vld[r]  = req_valid_q;
      assign lane_stt[r]  = req_start_q;
      assign lane_any[r]  = req_valid_q;
    end else begin : g_chain
      logic [r-1:0][IFMAP_BITWIDTH-1:0] dat_q, dat_d;
      logic [r-1:0]                     vld_q, vld_d;
      logic [r-1:0]                     stt_q, stt_d;

      always_comb begin
        dat_d[0] = rd_data_q[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH];
        vld_d[0] = req_valid_q;
        stt_d[0] = req_start_q;
        for (int s = 1; s < r; s++) begin
          dat_d[s] = dat_q[s-1];
          vld_d[s] = vld_q[s-1];
          stt_d[s] = stt_q[s-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dat_q <= '0;
          vld_q <= '0;
          stt_q <= '0;
        end else begin
          dat_q <= dat_d;
          vld_q <= vld_d;
          stt_q <= stt_d;
        end
      end

      assign lane_data[r] = dat_q[r-1];
      assign lane_vld[r]  = vld_q[r-1];
      assign lane_stt[r]  = stt_q[r-1];
      assign lane_any[r]  = |vld_q;
    end
  end

  // Invalid lanes drive zeros so the array can accumulate them harmlessly.
  always_comb begin
    ifmap_data_out  = '0;
    ifmap_valid_out = '0;
    ifmap_start_out = '0;
    ifmap_busy_out  = 1'b0;
    for (int i = 0; i < MAC_ROW; i++) begin
      ifmap_valid_out[i] = lane_vld[i];
      ifmap_start_out[i] = lane_vld[i] & lane_stt[i];
      if (lane_vld[i]) begin
        ifmap_data_out[i*IFMAP_BITWIDTH +: IFMAP_BITWIDTH] = lane_data[i];
      end
      ifmap_busy_out = ifmap_busy_out | lane_any[i];
    end
  end

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Directed bench for ifmap_skew_feeder: reset, single read, burst, collision, start tags,
// and mid-stream reset with memory retention.
module tb_ifmap_skew_feeder;

  localparam int unsigned MacRow = 16;
  localparam int unsigned Bw     = 16;
  localparam int unsigned Aw     = 9;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_en_in;
  logic [Aw-1:0]         wr_addr_in;
  logic [MacRow*Bw-1:0]  wr_data_in;
  logic                  ifmap_start_in;
  logic [Aw-1:0]         ifmap_addr_in;
  logic                  ifmap_read_en_in;
  logic [MacRow*Bw-1:0]  ifmap_data_out;
  logic [MacRow-1:0]     ifmap_valid_out;
  logic [MacRow-1:0]     ifmap_start_out;
  logic                  ifmap_busy_out;

  ifmap_skew_feeder #(
    .MAC_ROW        (MacRow),
    .IFMAP_BITWIDTH (Bw),
    .IFMAP_ADDR_BIT (Aw)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en_in         (wr_en_in),
    .wr_addr_in       (wr_addr_in),
    .wr_data_in       (wr_data_in),
    .ifmap_start_in   (ifmap_start_in),
    .ifmap_addr_in    (ifmap_addr_in),
    .ifmap_read_en_in (ifmap_read_en_in),
    .ifmap_data_out   (ifmap_data_out),
    .ifmap_valid_out  (ifmap_valid_out),
    .ifmap_start_out  (ifmap_start_out),
    .ifmap_busy_out   (ifmap_busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rd;
    bit            st;
    logic [Aw-1:0] ra;
    bit            wr;
    logic [Aw-1:0] wa;
    logic [255:0]  wd;
  } step_t;

  step_t        steps[$];
  logic [255:0] model_mem [512];
  int           n_cmp  = 0;
  int           n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " data"},  256'(ifmap_data_out),  '0);
    chk({tag, " valid"}, 256'(ifmap_valid_out), '0);
    chk({tag, " start"}, 256'(ifmap_start_out), '0);
    chk({tag, " busy"},  256'(ifmap_busy_out),  '0);
  endtask

  task automatic idle_inputs();
    wr_en_in         = 1'b0;
    ifmap_read_en_in = 1'b0;
    ifmap_start_in   = 1'b0;
  endtask

  task automatic do_write(input logic [Aw-1:0] a, input logic [255:0] d);
    wr_en_in   = 1'b1;
    wr_addr_in = a;
    wr_data_in = d;
    tick();
    wr_en_in   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic add_rd(input logic [Aw-1:0] a, input bit st);
    step_t s;
    s.rd = 1'b1; s.st = st; s.ra = a; s.wr = 1'b0; s.wa = '0; s.wd = '0;
    steps.push_back(s);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk_zero($sformatf("%s c%0d", tag, i + 1));
    end
  endtask

  // Drives the queued steps on consecutive edges and checks every row each cycle:
  // request j (edge j) shows on row r during cycle j+1+r; busy spans cycles j+1..j+16.
  task automatic run_steps(input string tag);
    int           n;
    logic [255:0] cap[$];
    bit           capv[$];
    bit           caps[$];
    logic [255:0] exp_d, w;
    logic [15:0]  exp_v, exp_s;
    logic         exp_b;
    n = steps.size();
    for (int i = 0; i < n + int'(MacRow) + 1; i++) begin
      if (i < n) begin
        ifmap_read_en_in = steps[i].rd;
        ifmap_start_in   = steps[i].st;
        ifmap_addr_in    = steps[i].ra;
        wr_en_in         = steps[i].wr;
        wr_addr_in       = steps[i].wa;
        wr_data_in       = steps[i].wd;
        cap.push_back(model_mem[steps[i].ra]);
        capv.push_back(steps[i].rd);
        caps.push_back(steps[i].st & steps[i].rd);
        if (steps[i].wr) model_mem[steps[i].wa] = steps[i].wd;
      end else begin
        idle_inputs();
      end
      tick();
      exp_d = '0; exp_v = '0; exp_s = '0; exp_b = 1'b0;
      for (int r = 0; r < int'(MacRow); r++) begin
        int j;
        j = i - r;
        if (j >= 0 && j < n && capv[j]) begin
          w = cap[j];
          exp_v[r] = 1'b1;
          exp_s[r] = caps[j];
          exp_d[r*16 +: 16] = w[r*16 +: 16];
        end
      end
      for (int j = 0; j < n; j++) begin
        if (capv[j] && i >= j && i <= j + 15) exp_b = 1'b1;
      end
      chk($sformatf("%s c%0d data", tag, i + 1),  ifmap_data_out, exp_d);
      chk($sformatf("%s c%0d valid", tag, i + 1), 256'(ifmap_valid_out), 256'(exp_v));
      chk($sformatf("%s c%0d start", tag, i + 1), 256'(ifmap_start_out), 256'(exp_s));
      chk($sformatf("%s c%0d busy", tag, i + 1),  256'(ifmap_busy_out), 256'(exp_b));
    end
    idle_inputs();
    steps.delete();
  endtask

  initial begin
    logic [255:0] d;
    step_t        s;

    // Reset with a request pending
    wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;
    ifmap_read_en_in = 1'b1; ifmap_start_in = 1'b1; ifmap_addr_in = '0;
    rst = 1'b1;
    #1;
    chk_zero("rst_init");
    tick();
    tick();
    chk_zero("rst_held");
    idle_inputs();
    rst = 1'b0;
    check_idle("post_rst", 4);

    // Single read: lane r = r+1
    for (int r = 0; r < 16; r++) d[r*16 +: 16] = 16'(r + 1);
    do_write(9'd5, d);
    add_rd(9'd5, 1'b0);
    run_steps("single");

    // Burst: lane value = 16*addr + r
    for (int a = 0; a < 8; a++) begin
      for (int r = 0; r < 16; r++) d[r*16 +: 16] = 16'(16 * a + r);
      do_write(9'(a), d);
    end
    for (int a = 0; a < 4; a++) add_rd(9'(a), 1'b0);
    run_steps("burst");

    // Collision: read-first, then new data next cycle
    do_write(9'd9, {16{16'hAAAA}});
    s.rd = 1'b1; s.st = 1'b0; s.ra = 9'd9; s.wr = 1'b1; s.wa = 9'd9; s.wd = {16{16'h5555}};
    steps.push_back(s);
    add_rd(9'd9, 1'b0);
    run_steps("collide");

    // Start tags, including a start without read_en that must vanish
    for (int r = 0; r < 16; r++) d[r*16 +: 16] = 16'h7000 + 16'(r);
    do_write(9'd7, d);
    add_rd(9'd7, 1'b1);
    s.rd = 1'b0; s.st = 1'b1; s.ra = 9'd7; s.wr = 1'b0; s.wa = '0; s.wd = '0;
    steps.push_back(s);
    add_rd(9'd7, 1'b0);
    steps.push_back(s);
    run_steps("start");

    // Mid-stream reset: reads 0..7 interrupted at the fourth edge
    for (int a = 0; a < 4; a++) begin
      ifmap_read_en_in = 1'b1;
      ifmap_addr_in    = 9'(a);
      tick();
    end
    ifmap_addr_in = 9'd4;
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    tick();
    chk_zero("mid_rst_held");
    idle_inputs();
    rst = 1'b0;
    check_idle("after_mid_rst", 20);
    add_rd(9'd2, 1'b0);
    run_steps("retain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
